// File: rtl/ula_mdu.sv
// ============================================================================
// Module  : ula_mdu
// Brief   : Iterative RV M-extension multiply/divide unit (shift-add multiply,
//           restoring divide, one bit per cycle) with ready/valid handshakes.
//           Define MDU_WORD_OPS_EN to enable the W-variant ops via the word port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ula_mdu #(
    parameter int N = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [2:0]   seletor,
    input  logic         word,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Y,
    output logic         div_by_zero,
    output logic         zero
);

    localparam int            c_H      = N / 2;
    localparam int            c_CW     = $clog2(N + 1);
    localparam logic [c_CW-1:0] c_ITER_N = c_CW'(N);
    localparam logic [c_CW-1:0] c_ITER_H = c_CW'(N / 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic            r_in_ready, r_out_valid, r_dbz, r_zero;
    logic [N-1:0]    r_y;
    logic [2*N-1:0]  r_acc;
    logic [2*N-1:0]  r_mcand;
    logic [N-1:0]    r_opb;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_op;
    logic            r_word, r_qneg, r_rneg, r_fast, r_fast_dbz;
    logic [N-1:0]    r_fast_res;

    logic w_word;
`ifdef MDU_WORD_OPS_EN
    assign w_word = word;
`else
    logic w_unused_word;
    assign w_word        = 1'b0;
    assign w_unused_word = word;
`endif

    // Operand conditioning at the accept edge: extension, signs, magnitudes, fast path.
    logic         w_is_div, w_a_sgn_op, w_b_sgn_op, w_sa, w_sb;
    logic         w_b_zero, w_ovf, w_fast;
    logic [N-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_a_res, w_fast_res;

    assign w_is_div   = seletor[2];
    assign w_a_sgn_op = seletor[2] ? ~seletor[0] : (seletor[1:0] != 2'b11);
    assign w_b_sgn_op = seletor[2] ? ~seletor[0] : ~seletor[1];
    assign w_a_ext    = w_word ? {{c_H{w_a_sgn_op & A[c_H-1]}}, A[c_H-1:0]} : A;
    assign w_b_ext    = w_word ? {{c_H{w_b_sgn_op & B[c_H-1]}}, B[c_H-1:0]} : B;
    assign w_sa       = w_a_sgn_op & w_a_ext[N-1];
    assign w_sb       = w_b_sgn_op & w_b_ext[N-1];
    assign w_a_mag    = w_sa ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag    = w_sb ? (~w_b_ext + 1'b1) : w_b_ext;
    assign w_b_zero   = (w_b_ext == '0);
    assign w_ovf      = w_is_div & w_a_sgn_op & (w_word
                        ? (A[c_H-1:0] == {1'b1, {(c_H-1){1'b0}}}) && (B[c_H-1:0] == {c_H{1'b1}})
                        : (A == {1'b1, {(N-1){1'b0}}}) && (B == {N{1'b1}}));
    assign w_fast     = w_is_div & (w_b_zero | w_ovf);
    assign w_a_res    = w_word ? {{c_H{A[c_H-1]}}, A[c_H-1:0]} : A;
    assign w_fast_res = w_b_zero ? (seletor[1] ? w_a_res : {N{1'b1}})
                                 : (seletor[1] ? {N{1'b0}} : w_a_res);

    // One restoring-division step on {remainder, dividend/quotient}.
    logic [N:0] w_rem_sh, w_rem_sub;
    logic       w_ge;
    assign w_rem_sh  = {r_acc[2*N-1:N], r_acc[N-1]};
    assign w_rem_sub = w_rem_sh - {1'b0, r_opb};
    assign w_ge      = ~w_rem_sub[N];

    // Sign fix-up and result selection.
    logic [2*N-1:0] w_prod;
    logic [N-1:0]   w_quo, w_rem, w_res_n, w_result;
    assign w_prod   = r_qneg ? (~r_acc + 1'b1) : r_acc;
    assign w_quo    = r_qneg ? (~r_acc[N-1:0] + 1'b1) : r_acc[N-1:0];
    assign w_rem    = r_rneg ? (~r_acc[2*N-1:N] + 1'b1) : r_acc[2*N-1:N];
    assign w_res_n  = r_op[2] ? (r_op[1] ? w_rem : w_quo)
                              : (((r_op[1:0] == 2'b00) || r_word) ? w_prod[N-1:0] : w_prod[2*N-1:N]);
    assign w_result = r_fast ? r_fast_res
                             : (r_word ? {{c_H{w_res_n[c_H-1]}}, w_res_n[c_H-1:0]} : w_res_n);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_dbz       <= 1'b0;
            r_zero      <= 1'b1;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mcand     <= '0;
            r_opb       <= '0;
            r_op        <= '0;
            r_word      <= 1'b0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_fast      <= 1'b0;
            r_fast_dbz  <= 1'b0;
            r_fast_res  <= '0;
        end else if (flush) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_state    <= S_BUSY;
                        r_in_ready <= 1'b0;
                        r_op       <= seletor;
                        r_word     <= w_word;
                        r_qneg     <= w_sa ^ w_sb;
                        r_rneg     <= w_sa;
                        r_fast     <= w_fast;
                        r_fast_dbz <= w_is_div & w_b_zero;
                        r_fast_res <= w_fast_res;
                        r_mcand    <= {{N{1'b0}}, w_a_mag};
                        r_opb      <= w_b_mag;
                        r_cnt      <= w_fast ? '0 : (w_word ? c_ITER_H : c_ITER_N);
                        // Dividend sits at the top of the shift register so W ops need only N/2 steps.
                        if (!w_is_div)
                            r_acc <= '0;
                        else if (w_word)
                            r_acc <= {{N{1'b0}}, w_a_mag << c_H};
                        else
                            r_acc <= {{N{1'b0}}, w_a_mag};
                    end
                end
                S_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - c_CW'(1);
                        if (r_op[2]) begin
                            r_acc <= {(w_ge ? w_rem_sub[N-1:0] : w_rem_sh[N-1:0]), r_acc[N-2:0], w_ge};
                        end else begin
                            if (r_opb[0])
                                r_acc <= r_acc + r_mcand;
                            r_mcand <= r_mcand << 1;
                            r_opb   <= r_opb >> 1;
                        end
                    end else begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_y         <= w_result;
                        r_dbz       <= r_fast_dbz;
                        r_zero      <= (w_result == '0);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign Y           = r_y;
    assign div_by_zero = r_dbz;
    assign zero        = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_ula_mdu.sv
// ============================================================================
// Module  : tb_ula_mdu
// Brief   : Directed self-checking bench for ula_mdu (N=16).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ula_mdu;

    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic [2:0]   seletor = '0;
    logic         word = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         in_ready, out_valid, div_by_zero, zero;
    logic [N-1:0] Y;

    int errors = 0;
    int checks = 0;

    ula_mdu #(.N(N)) dut (
        .clock       (clock),
        .reset       (reset),
        .A           (A),
        .B           (B),
        .seletor     (seletor),
        .word        (word),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Y           (Y),
        .div_by_zero (div_by_zero),
        .zero        (zero)
    );

    always #5 clock = ~clock;

    // Issues one op and waits (bounded) for out_valid; lat = edges after accept, -1 on timeout.
    task automatic run_op(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                          input logic w, output logic [N-1:0] y, output logic dbz,
                          output logic z, output int lat);
        int guard;
        @(negedge clock);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        A = a; B = b; seletor = op; word = w; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clock);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        y = Y; dbz = div_by_zero; z = zero;
    endtask

    task automatic handshake();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (Y !== 16'h0000)       begin errors++; $display("FAIL reset_Y: got %h expected 0000", Y); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        checks++; if (zero !== 1'b1)        begin errors++; $display("FAIL reset_zero: got %b expected 1", zero); end
    endtask

    task automatic test_mul();
        logic [2:0]   ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [N-1:0] exp [4] = '{16'hFFFA, 16'hFFFF, 16'h0002, 16'h0002};
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 16'h0003, 16'hFFFE, 1'b0, y, d, z, lat);
            checks++; if (y !== exp[i]) begin errors++; $display("FAIL mul_op%0d_Y: got %h expected %h", ops[i], y, exp[i]); end
            checks++; if (lat !== 17)   begin errors++; $display("FAIL mul_op%0d_latency: got %0d expected 17", ops[i], lat); end
            handshake();
        end
    endtask

    task automatic test_div();
        logic [2:0]   ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [N-1:0] exp [4] = '{16'hFFFD, 16'hFFFF, 16'h7FFC, 16'h0001};
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 16'hFFF9, 16'h0002, 1'b0, y, d, z, lat);
            checks++; if (y !== exp[i]) begin errors++; $display("FAIL div_op%0d_Y: got %h expected %h", ops[i], y, exp[i]); end
            checks++; if (d !== 1'b0)   begin errors++; $display("FAIL div_op%0d_dbz: got %b expected 0", ops[i], d); end
            checks++; if (lat !== 17)   begin errors++; $display("FAIL div_op%0d_latency: got %0d expected 17", ops[i], lat); end
            handshake();
        end
    endtask

    task automatic test_div_zero();
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
        run_op(3'd4, 16'h1234, 16'h0000, 1'b0, y, d, z, lat);
        checks++; if (y !== 16'hFFFF) begin errors++; $display("FAIL divz_div_Y: got %h expected FFFF", y); end
        checks++; if (d !== 1'b1)     begin errors++; $display("FAIL divz_div_dbz: got %b expected 1", d); end
        checks++; if (lat !== 1)      begin errors++; $display("FAIL divz_div_latency: got %0d expected 1", lat); end
        handshake();
        run_op(3'd7, 16'h1234, 16'h0000, 1'b0, y, d, z, lat);
        checks++; if (y !== 16'h1234) begin errors++; $display("FAIL divz_remu_Y: got %h expected 1234", y); end
        checks++; if (d !== 1'b1)     begin errors++; $display("FAIL divz_remu_dbz: got %b expected 1", d); end
        checks++; if (lat !== 1)      begin errors++; $display("FAIL divz_remu_latency: got %0d expected 1", lat); end
        handshake();
    endtask

    task automatic test_overflow();
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
        run_op(3'd4, 16'h8000, 16'hFFFF, 1'b0, y, d, z, lat);
        checks++; if (y !== 16'h8000) begin errors++; $display("FAIL ovf_div_Y: got %h expected 8000", y); end
        checks++; if (d !== 1'b0)     begin errors++; $display("FAIL ovf_div_dbz: got %b expected 0", d); end
        checks++; if (lat !== 1)      begin errors++; $display("FAIL ovf_div_latency: got %0d expected 1", lat); end
        handshake();
        run_op(3'd6, 16'h8000, 16'hFFFF, 1'b0, y, d, z, lat);
        checks++; if (y !== 16'h0000) begin errors++; $display("FAIL ovf_rem_Y: got %h expected 0000", y); end
        checks++; if (z !== 1'b1)     begin errors++; $display("FAIL ovf_rem_zero: got %b expected 1", z); end
        checks++; if (lat !== 1)      begin errors++; $display("FAIL ovf_rem_latency: got %0d expected 1", lat); end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
        run_op(3'd0, 16'h0003, 16'hFFFE, 1'b0, y, d, z, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checks++; if (Y !== 16'hFFFA)   begin errors++; $display("FAIL bp_hold_Y_%0d: got %h expected FFFA", i, Y); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d: got %b expected 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_hold_ready_%0d: got %b expected 0", i, in_ready); end
        end
        // An in_valid during the handshake cycle must not be taken.
        @(negedge clock);
        out_ready = 1'b1; in_valid = 1'b1; A = 16'h0001; B = 16'h0001; seletor = 3'd0;
        @(posedge clock);
        #1;
        out_ready = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", out_valid); end
        @(negedge clock);
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_no_reaccept: got %b expected 1", in_ready); end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        @(negedge clock);
        A = 16'h7777; B = 16'h0003; seletor = 3'd5; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clock);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL flush_idle: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0)   begin errors++; $display("FAIL flush_never_valid: got %b expected 0", seen); end
        checks++; if (Y !== 16'hFFFA)  begin errors++; $display("FAIL flush_Y_kept: got %h expected FFFA", Y); end
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        A = 16'h0005; B = 16'h0007; seletor = 3'd0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1)    begin errors++; $display("FAIL rmid_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
        checks++; if (Y !== 16'h0000)       begin errors++; $display("FAIL rmid_Y: got %h expected 0000", Y); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL rmid_dbz: got %b expected 0", div_by_zero); end
        checks++; if (zero !== 1'b1)        begin errors++; $display("FAIL rmid_zero: got %b expected 1", zero); end
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clock);
        checks++; if (out_valid !== 1'b0)   begin errors++; $display("FAIL rmid_discarded: got %b expected 0", out_valid); end
    endtask

    task automatic test_word();
        logic [N-1:0] y;
        logic         d, z;
        int           lat;
`ifdef MDU_WORD_OPS_EN
        run_op(3'd0, 16'h00FF, 16'h0002, 1'b1, y, d, z, lat);
        checks++; if (y !== 16'hFFFE) begin errors++; $display("FAIL mulw_Y: got %h expected FFFE", y); end
        checks++; if (lat !== 9)      begin errors++; $display("FAIL mulw_latency: got %0d expected 9", lat); end
        handshake();
        run_op(3'd4, 16'hABF9, 16'h3302, 1'b1, y, d, z, lat);
        checks++; if (y !== 16'hFFFD) begin errors++; $display("FAIL divw_Y: got %h expected FFFD", y); end
        checks++; if (lat !== 9)      begin errors++; $display("FAIL divw_latency: got %0d expected 9", lat); end
        handshake();
`else
        run_op(3'd0, 16'h00FF, 16'h0002, 1'b1, y, d, z, lat);
        checks++; if (y !== 16'h01FE) begin errors++; $display("FAIL word_ignored_Y: got %h expected 01FE", y); end
        checks++; if (lat !== 17)     begin errors++; $display("FAIL word_ignored_latency: got %0d expected 17", lat); end
        handshake();
`endif
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_overflow();
        test_word();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ula_mdu.md
Name: ula_mdu

Overview:
Iterative multiply/divide unit: the RV M-extension companion to the combinational ULA in the execute stage, parametrised in width N. Shift-add multiply and restoring divide, one bit per cycle. Ready/valid handshake on both sides so the core stalls while it is busy. Resolves divide-by-zero and signed overflow in one cycle.

Parameters:
N, 16, operand/result width (even, >=4)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
A  input  N  operand rs1
B  input  N  operand rs2
seletor  input  3  op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
word  input  1  W-variant select (see Optional Feature)
flush  input  1  synchronous cancel of the in-flight op
in_valid  input  1  operands/op valid
in_ready  output  1  unit can accept (state IDLE)
out_valid  output  1  Y valid
out_ready  input  1  consumer takes Y
Y  output  N  result
div_by_zero  output  1  result came from a DIV/DIVU/REM/REMU with B==0
zero  output  1  Y==0, valid with out_valid

Behaviour:
- Reset (async): state IDLE, in_ready=1, out_valid=0, Y=0, div_by_zero=0, zero=1, counter=0.
- States: IDLE, BUSY, DONE.
- in_ready=1 only in IDLE.
- Accept: on an edge with in_valid&in_ready&~flush, latch A, B, seletor and word.
- Fast path (next edge goes to DONE, out_valid visible 1 cycle after accept):
  - div/rem with B==0: DIV/DIVU give all-ones; REM/REMU give A; div_by_zero=1.
  - DIV/REM with A==most-negative and B==all-ones: DIV gives A, REM gives 0.
- Normal path: IDLE->BUSY. Counter runs N iterations, then DONE. out_valid is visible N+1 edges after the accept edge.
- Multiply: form operand magnitudes (A signed for MUL/MULH/MULHSU, B signed for MUL/MULH), run an unsigned 2N-bit shift-add, negate if the signs differ. MUL returns low N bits; MULH/MULHSU/MULHU return high N bits.
- Divide: restoring division on magnitudes (signed for DIV/REM). Quotient sign = sA^sB; remainder sign = sA (truncating toward zero).
- DONE: out_valid=1. Y, div_by_zero and zero are held stable until out_valid&out_ready. That handshake goes to IDLE; in_ready rises on the following cycle (no same-cycle re-accept).
- flush: highest priority after reset. From any state the next edge goes to IDLE with out_valid=0. An in_valid in the same cycle is ignored. Y keeps its last value.
- Reset mid-operation: immediate IDLE; the in-flight op is discarded.
- Inputs other than in_valid/flush/out_ready are don't-care outside the accept edge.

Optional Feature:
- Macro MDU_WORD_OPS_EN.
- Defined: word=1 selects W ops (MULW, DIVW, DIVUW, REMW, REMUW).
  - Operands are the low N/2 bits, sign- or zero-extended per op.
  - Iteration count is N/2.
  - Result is the low N/2 bits sign-extended to N.
  - Fast-path checks use the N/2-bit values.
  - word=1 with MULH/MULHSU/MULHU behaves as MULW.
- Not defined: the word port is ignored (treated as 0) and all ops are N-bit.

Test Plan:
- N=16. MUL A=0x0003 B=0xFFFE -> Y=0xFFFA. MULH -> 0xFFFF. MULHU -> 0x0002. MULHSU -> 0x0002. out_valid exactly 17 edges after accept.
- DIV A=0xFFF9 B=0x0002 -> 0xFFFD; REM -> 0xFFFF. DIVU -> 0x7FFC; REMU -> 0x0001.
- DIV A=0x1234 B=0 -> Y=0xFFFF, div_by_zero=1. REMU same operands -> 0x1234. out_valid 1 edge after accept.
- DIV A=0x8000 B=0xFFFF -> 0x8000; REM -> 0x0000, zero=1. Fast path, div_by_zero=0.
- Backpressure: out_ready=0 for 5 cycles -> Y and out_valid held, in_ready=0. After the handshake edge, in_ready=1 on the next cycle.
- flush asserted at iteration 5 -> IDLE next edge, out_valid never rises.
- reset pulse mid-BUSY -> all outputs return to reset values without a clock edge.
- With MDU_WORD_OPS_EN: MULW (word=1, seletor=0) A=0x00FF B=0x0002 -> 0xFFFE after 9 edges.
